// File: rtl/sa2_operand_loader_pkg.sv
// Shared types and frame geometry for the 2x2 systolic array operand loader.
package sa2_pkg;

    localparam int N_A       = 16;
    localparam int N_B       = 9;
    localparam int FRAME_LEN = N_A + N_B;
    localparam int IDX_W     = 5;

    // Index of the final byte of a well-formed frame.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/sa2_operand_loader_if.sv
// Valid/ready byte stream carrying one operand frame (tile then filter).
interface sa2_operand_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    // Byte source driving the loader.
    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    // The loader itself.
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/sa2_operand_loader_watchdog.sv
// Run-phase watchdog: counts while enabled, flags expiry at TIMEOUT-1.
module sa2_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    // Counter restarts from zero on clear and holds once it reaches expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/sa2_operand_loader.sv
// Operand loader for the 2x2 systolic convolution array: captures a 25-byte
// frame (4x4 tile + 3x3 filter), runs the array, and recovers from length
// errors and a hung array.
module sa2_operand_loader
    import sa2_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sa2_operand_loader_if.slave   s,
    output logic [7:0]            a11, a12, a13, a14,
    output logic [7:0]            a21, a22, a23, a24,
    output logic [7:0]            a31, a32, a33, a34,
    output logic [7:0]            a41, a42, a43, a44,
    output logic [7:0]            b11, b12, b13,
    output logic [7:0]            b21, b22, b23,
    output logic [7:0]            b31, b32, b33,
    output logic                  active_sa2,
    input  logic                  done_sa2,
    output logic                  sa2_rst,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_len,
    output logic                  err_timeout
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             ready_q;
    logic             active_q;
    logic             busy_q;
    logic             sa2_rst_q;
    logic             frame_done_q;
    logic             err_len_q;
    logic             err_to_q;
    logic             hs;
    logic             wd_expire;
    logic [7:0]       ops [FRAME_LEN];

    assign hs = s.in_valid && ready_q;

    sa2_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state != RUN),
        .en     (state == RUN),
        .expire (wd_expire)
    );

    // Frame sequencing: load bytes, flush bad frames, run the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD;
            idx          <= '0;
            ready_q      <= 1'b0;
            active_q     <= 1'b0;
            busy_q       <= 1'b0;
            sa2_rst_q    <= 1'b1;
            frame_done_q <= 1'b0;
            err_len_q    <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            err_len_q    <= 1'b0;
            err_to_q     <= 1'b0;
            sa2_rst_q    <= 1'b0;
            case (state)
                LOAD: begin
                    ready_q <= 1'b1;
                    if (hs) begin
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (s.in_last) begin
                                state    <= RUN;
                                ready_q  <= 1'b0;
                                active_q <= 1'b1;
                                busy_q   <= 1'b1;
                            end else begin
                                state     <= FLUSH;
                                err_len_q <= 1'b1;
                            end
                        end else if (s.in_last) begin
                            idx       <= '0;
                            err_len_q <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    ready_q <= 1'b1;
                    if (hs && s.in_last) begin
                        state <= LOAD;
                    end
                end
                RUN: begin
                    // done_sa2 takes priority over a watchdog expiry in the same cycle
                    if (done_sa2 || wd_expire) begin
                        state    <= LOAD;
                        ready_q  <= 1'b1;
                        active_q <= 1'b0;
                        busy_q   <= 1'b0;
                        if (done_sa2) begin
                            frame_done_q <= 1'b1;
                        end else begin
                            err_to_q  <= 1'b1;
                            sa2_rst_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= LOAD;
                    idx      <= '0;
                    ready_q  <= 1'b1;
                    active_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    // Operand register file: written only by LOAD handshakes, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FRAME_LEN; i++) begin
                ops[i] <= '0;
            end
        end else if (hs && (state == LOAD)) begin
            ops[idx] <= s.in_data;
        end
    end

    assign s.in_ready   = ready_q;
    assign active_sa2   = active_q;
    assign busy         = busy_q;
    assign sa2_rst      = sa2_rst_q;
    assign frame_done   = frame_done_q;
    assign err_len      = err_len_q;
    assign err_timeout  = err_to_q;

    assign a11 = ops[0];
    assign a12 = ops[1];
    assign a13 = ops[2];
    assign a14 = ops[3];
    assign a21 = ops[4];
    assign a22 = ops[5];
    assign a23 = ops[6];
    assign a24 = ops[7];
    assign a31 = ops[8];
    assign a32 = ops[9];
    assign a33 = ops[10];
    assign a34 = ops[11];
    assign a41 = ops[12];
    assign a42 = ops[13];
    assign a43 = ops[14];
    assign a44 = ops[15];
    assign b11 = ops[16];
    assign b12 = ops[17];
    assign b13 = ops[18];
    assign b21 = ops[19];
    assign b22 = ops[20];
    assign b23 = ops[21];
    assign b31 = ops[22];
    assign b32 = ops[23];
    assign b33 = ops[24];

endmodule

// File: tb/tb_sa2_operand_loader.sv
// Randomized self-checking bench for sa2_operand_loader against a frame-level model.
module tb_sa2_operand_loader;

    localparam int TO = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       done_sa2 = 1'b0;
    logic [7:0] op [25];
    logic       active_sa2, sa2_rst, busy, frame_done, err_len, err_timeout;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] model [25];
    logic [7:0] frame [$];

    sa2_operand_loader_if src();

    sa2_operand_loader #(
        .TIMEOUT (TO),
        .CNT_W   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s           (src.slave),
        .a11 (op[0]),  .a12 (op[1]),  .a13 (op[2]),  .a14 (op[3]),
        .a21 (op[4]),  .a22 (op[5]),  .a23 (op[6]),  .a24 (op[7]),
        .a31 (op[8]),  .a32 (op[9]),  .a33 (op[10]), .a34 (op[11]),
        .a41 (op[12]), .a42 (op[13]), .a43 (op[14]), .a44 (op[15]),
        .b11 (op[16]), .b12 (op[17]), .b13 (op[18]),
        .b21 (op[19]), .b22 (op[20]), .b23 (op[21]),
        .b31 (op[22]), .b32 (op[23]), .b33 (op[24]),
        .active_sa2  (active_sa2),
        .done_sa2    (done_sa2),
        .sa2_rst     (sa2_rst),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_len     (err_len),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic check_ops(input string tag);
        for (int i = 0; i < 25; i++) begin
            n_checks++;
            if (op[i] !== model[i]) begin
                n_fail++;
                $display("FAIL %s operand[%0d] got %h expected %h", tag, i, op[i], model[i]);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input bit noise_done);
        int n = 0;
        src.in_valid = 1'b1;
        src.in_data  = d;
        src.in_last  = last;
        if (noise_done) done_sa2 = 1'($urandom);
        @(negedge clk);
        while (src.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (src.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_wait in_ready got %b expected 1", src.in_ready);
        end
        @(posedge clk);
        #1;
        src.in_valid = 1'b0;
        src.in_last  = 1'b0;
        done_sa2     = 1'b0;
    endtask

    // Sends the queued frame; done_after = 0 means the array never reports done.
    task automatic do_frame(input int done_after, input bit hold_valid, input bit noise_done);
        int len;
        bit runs;
        bit exp_el;
        bit exp_to;
        int exp_cycles;
        int cycles;
        len  = frame.size();
        runs = (len == 25);
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
            send_byte(frame[i], i == len - 1, noise_done);
            if (i < 25) model[i] = frame[i];
            exp_el = (len < 25 && i == len - 1) || (len > 25 && i == 24);
            n_checks++;
            if (err_len !== exp_el) begin
                n_fail++;
                $display("FAIL err_len byte %0d of %0d got %b expected %b", i, len, err_len, exp_el);
            end
            n_checks++;
            if (active_sa2 !== (runs && i == len - 1)) begin
                n_fail++;
                $display("FAIL active_load byte %0d of %0d got %b", i, len, active_sa2);
            end
            n_checks++;
            if (frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_done_in_load byte %0d got %b expected 0", i, frame_done);
            end
        end
        if (!runs) begin
            n_checks++;
            if (src.in_ready !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL after_bad_frame in_ready=%b busy=%b expected 1,0", src.in_ready, busy);
            end
            check_ops("bad_frame");
            return;
        end
        n_checks++;
        if (src.in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL run_entry in_ready=%b busy=%b expected 0,1", src.in_ready, busy);
        end
        check_ops("run_entry");
        exp_to     = (done_after < 1 || done_after > TO);
        exp_cycles = exp_to ? TO : done_after;
        cycles     = 0;
        while (active_sa2 === 1'b1 && cycles < TO + 10) begin
            if (hold_valid) begin
                src.in_valid = 1'b1;
                src.in_data  = 8'($urandom);
            end
            if (cycles == done_after - 1) done_sa2 = 1'b1;
            @(negedge clk);
            n_checks++;
            if (src.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_in_run cycle %0d got %b expected 0", cycles, src.in_ready);
            end
            @(posedge clk);
            #1;
            done_sa2     = 1'b0;
            src.in_valid = 1'b0;
            cycles++;
        end
        n_checks++;
        if (cycles !== exp_cycles) begin
            n_fail++;
            $display("FAIL active_length got %0d cycles expected %0d", cycles, exp_cycles);
        end
        n_checks++;
        if (frame_done !== !exp_to || err_timeout !== exp_to || sa2_rst !== exp_to) begin
            n_fail++;
            $display("FAIL run_exit frame_done=%b err_timeout=%b sa2_rst=%b expected %b,%b,%b",
                     frame_done, err_timeout, sa2_rst, !exp_to, exp_to, exp_to);
        end
        n_checks++;
        if (src.in_ready !== 1'b1 || busy !== 1'b0 || active_sa2 !== 1'b0) begin
            n_fail++;
            $display("FAIL run_exit_ready in_ready=%b busy=%b active=%b expected 1,0,0",
                     src.in_ready, busy, active_sa2);
        end
        check_ops("run_exit");
        @(posedge clk);
        #1;
        n_checks++;
        if (frame_done !== 1'b0 || err_timeout !== 1'b0 || sa2_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_width frame_done=%b err_timeout=%b sa2_rst=%b expected 0,0,0",
                     frame_done, err_timeout, sa2_rst);
        end
    endtask

    task automatic fill_random(input int len);
        frame.delete();
        for (int i = 0; i < len; i++) frame.push_back(8'($urandom));
    endtask

    task automatic test_reset;
        src.in_valid = 1'b0;
        src.in_data  = '0;
        src.in_last  = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 25; i++) model[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (active_sa2 !== 1'b0 || busy !== 1'b0 || sa2_rst !== 1'b1 || src.in_ready !== 1'b0 ||
            frame_done !== 1'b0 || err_len !== 1'b0 || err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs active=%b busy=%b sa2_rst=%b ready=%b fd=%b el=%b et=%b expected 0,0,1,0,0,0,0",
                     active_sa2, busy, sa2_rst, src.in_ready, frame_done, err_len, err_timeout);
        end
        check_ops("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (src.in_ready !== 1'b1 || sa2_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release in_ready=%b sa2_rst=%b expected 1,0", src.in_ready, sa2_rst);
        end
    endtask

    task automatic test_basic;
        frame.delete();
        for (int i = 1; i <= 25; i++) frame.push_back(8'(i));
        do_frame(10, 1'b0, 1'b0);
        n_checks++;
        if (op[0] !== 8'd1 || op[15] !== 8'd16 || op[16] !== 8'd17 || op[24] !== 8'd25) begin
            n_fail++;
            $display("FAIL basic_corners a11=%0d a44=%0d b11=%0d b33=%0d expected 1,16,17,25",
                     op[0], op[15], op[16], op[24]);
        end
    endtask

    task automatic test_short_frame;
        fill_random(20);
        do_frame(5, 1'b0, 1'b0);
        frame.delete();
        for (int i = 0; i < 25; i++) frame.push_back(8'hFF);
        do_frame(int'($urandom_range(1, 6)), 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) begin
            n_checks++;
            if (op[i] !== 8'hFF) begin
                n_fail++;
                $display("FAIL all_ff operand[%0d] got %h expected ff", i, op[i]);
            end
        end
    endtask

    task automatic test_long_frame;
        fill_random(27);
        do_frame(5, 1'b0, 1'b0);
        fill_random(25);
        do_frame(3, 1'b0, 1'b0);
    endtask

    task automatic test_timeout;
        fill_random(25);
        do_frame(0, 1'b0, 1'b0);
        fill_random(25);
        do_frame(TO, 1'b0, 1'b0);
        fill_random(25);
        do_frame(1, 1'b0, 1'b0);
    endtask

    task automatic test_hold_valid_in_run;
        fill_random(25);
        do_frame(7, 1'b1, 1'b0);
    endtask

    task automatic test_done_in_load;
        fill_random(25);
        do_frame(4, 1'b0, 1'b1);
        fill_random(13);
        do_frame(4, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        int len;
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 4))
                0:       len = int'($urandom_range(1, 24));
                1:       len = int'($urandom_range(26, 30));
                default: len = 25;
            endcase
            fill_random(len);
            do_frame(int'($urandom_range(0, TO + 2)), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_run;
        fill_random(25);
        for (int i = 0; i < 25; i++) send_byte(frame[i], i == 24, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        done_sa2 = 1'b1;
        for (int i = 0; i < 25; i++) model[i] = 8'h00;
        #1;
        n_checks++;
        if (active_sa2 !== 1'b0 || busy !== 1'b0 || sa2_rst !== 1'b1 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_reset active=%b busy=%b sa2_rst=%b frame_done=%b expected 0,0,1,0",
                     active_sa2, busy, sa2_rst, frame_done);
        end
        check_ops("mid_run_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_sa2 = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (frame_done !== 1'b0 || err_timeout !== 1'b0 || src.in_ready !== 1'b1 || sa2_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset fd=%b et=%b ready=%b sa2_rst=%b expected 0,0,1,0",
                     frame_done, err_timeout, src.in_ready, sa2_rst);
        end
        fill_random(25);
        do_frame(6, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_short_frame;
        test_long_frame;
        test_timeout;
        test_hold_valid_in_run;
        test_done_in_load;
        test_random;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sa2_operand_loader.md
# sa2_operand_loader

Upstream feeder for the 2x2 systolic convolution array. Receives one 25-byte operand frame on a valid/ready byte stream: a 4x4 input tile followed by a 3x3 filter. Holds the frame in registers that drive the array's a11..a44 / b11..b33 inputs, raises active_sa2 until the array reports done_sa2, then accepts the next frame. Length errors are detected, and a hung array is recovered by a watchdog.

## Interface
Parameters:
- TIMEOUT, 64: maximum RUN cycles without done_sa2 before abort (>= 2).
- CNT_W, 7: watchdog counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_last  in  1  marks the final byte of a frame.
- in_ready  out  1  loader accepts a byte this cycle.
- a11..a44  out  8 each (16 ports)  tile operands, row-major.
- b11..b33  out  8 each (9 ports)  filter operands, row-major.
- active_sa2  out  1  run request to the array; level, held for the whole run.
- done_sa2  in  1  array completion, sampled only in RUN.
- sa2_rst  out  1  active-high reset to the array.
- busy  out  1  high in RUN.
- frame_done  out  1  one-cycle pulse on normal completion.
- err_len  out  1  one-cycle pulse on frame length error.
- err_timeout  out  1  one-cycle pulse on watchdog abort.

## Operation
- A handshake occurs when in_valid and in_ready are both high.
- The 5-bit index idx selects the destination register:
  - idx 0..15 write a11,a12,a13,a14,a21,...,a44.
  - idx 16..24 write b11,b12,b13,b21,...,b33.
- There are three states:
  - LOAD: in_ready=1. Each handshake writes in_data[idx] and increments idx.
    - Handshake at idx=24 with in_last=1: go to RUN, idx:=0.
    - Handshake at idx=24 with in_last=0: pulse err_len, go to FLUSH.
    - Handshake with in_last=1 and idx<24: the byte is written, err_len pulses, idx:=0, stay in LOAD, and no run starts. The next frame overwrites the registers.
  - FLUSH: in_ready=1. Bytes are dropped with no register writes. A handshake with in_last=1 returns to LOAD with idx=0.
  - RUN: in_ready=0, active_sa2=1, busy=1, operand registers frozen. The watchdog counts from 0 each cycle.
    - done_sa2=1: go to LOAD and pulse frame_done.
    - Counter reaches TIMEOUT-1 with done_sa2 still 0: pulse err_timeout and sa2_rst, then go to LOAD.
    - done_sa2 and the timeout in the same cycle: done wins (frame_done, no error).
- done_sa2 is ignored outside RUN.
- Operand registers are never cleared except by reset.

## Timing
- Reset values while rst_n=0: all operands 0, active_sa2=0, busy=0, all pulses 0, sa2_rst=1, in_ready=0, state LOAD, idx 0, counter 0.
- First cycle after rst_n rises: in_ready=1 and sa2_rst=0.
- in_ready is decoded from the registered state. No combinational path exists from in_valid to in_ready.
- The operand register update is visible the cycle after its handshake.
- 25th handshake at edge k: active_sa2=1 and in_ready=0 from edge k. All operands are stable from edge k onward.
- done_sa2 sampled high at edge m: active_sa2=0, in_ready=1, and frame_done=1 for the cycle after m. The next frame's first byte can be accepted in that same cycle.
- Timeout: active_sa2 is high for exactly TIMEOUT cycles. Then err_timeout=1 and sa2_rst=1 for one cycle with active_sa2=0, and in_ready=1 in that same cycle.
- Minimum frame-to-frame spacing is 25 load cycles plus the array run time.
- rst_n asserted mid-load or mid-run aborts immediately. No pulses are emitted.

## Structure
- Package sa2_pkg holds:
  - state enum {LOAD, FLUSH, RUN};
  - constants N_A=16, N_B=9, FRAME_LEN=25, IDX_W=5.
- Sub-module sa2_watchdog: CNT_W counter with clear and enable inputs and an expire output at TIMEOUT-1.
- The operand register file stays inline as a 25-entry byte array, mapped to the named ports.

## Test plan
- Bytes 1..25 with in_last on byte 25, then done_sa2 after 10 cycles -> a11=1, a44=16, b11=17, b33=25. active_sa2 high for exactly 10 cycles, then frame_done for 1 cycle.
- in_last on byte 20 -> err_len pulse, active_sa2 stays 0. A following correct frame of 0xFF bytes runs normally with all operands 0xFF.
- 27-byte frame (in_last on byte 27) -> err_len pulse at byte 25, bytes 26–27 dropped, no run, LOAD afterwards.
- done_sa2 never asserted, TIMEOUT=8 -> active_sa2 high for 8 cycles, then err_timeout and sa2_rst for one cycle, in_ready=1.
- Extra checks:
  - in_valid held high during RUN -> in_ready stays 0 and operands are unchanged.
  - done_sa2 pulsed during LOAD -> ignored.
- rst_n pulsed low mid-RUN -> active_sa2=0 and all operands 0 immediately. sa2_rst=1 while rst_n is low, and no frame_done.
